// File: rtl/seq_core.sv
// seq_core: multi-cycle 4-register core with ZNC flags, PC-relative branches and
// handshaked fetch/output ports. Define CORE_MUL_EN to make opcode A a single-cycle MUL.
`timescale 1ns/1ps
module seq_core #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_valid,
  input  logic [15:0]       imem_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [2:0]        znc,
  output logic              halted,
  output logic [PC_W-1:0]   pc
);

  typedef enum logic [1:0] {FETCH, EXEC, OUTW, HALT} state_t;

  localparam logic [3:0] OP_LDI = 4'h1, OP_MOV = 4'h2, OP_ADD = 4'h3, OP_SUB = 4'h4,
                         OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7, OP_SHL = 4'h8,
                         OP_SHR = 4'h9, OP_MUL = 4'hA, OP_BRZ = 4'hB, OP_BRC = 4'hC,
                         OP_JMP = 4'hD, OP_OUT = 4'hE, OP_HLT = 4'hF;

  state_t              state_reg, state_next;
  logic [15:0]         ir_reg;
  logic [PC_W-1:0]     pc_reg;
  logic [DATA_W-1:0]   regs_reg [4];
  logic [2:0]          znc_reg;
  logic [DATA_W-1:0]   out_data_reg;

  logic [3:0]          op;
  logic [1:0]          rd, rs;
  logic [7:0]          imm8;
  logic [DATA_W-1:0]   rd_val, rs_val, imm_data;
  logic [PC_W-1:0]     imm_pc;
  logic [DATA_W:0]     add_full, sub_full;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c, reg_wr, flag_wr, br_take;
  logic [3:0]          rf_we;

  assign op   = ir_reg[15:12];
  assign rd   = ir_reg[11:10];
  assign rs   = ir_reg[9:8];
  assign imm8 = ir_reg[7:0];

  assign rd_val   = regs_reg[rd];
  assign rs_val   = regs_reg[rs];
  assign imm_data = DATA_W'(signed'(imm8));
  assign imm_pc   = PC_W'(signed'(imm8));

  // The extra top bit of the subtraction is the unsigned borrow.
  assign add_full = {1'b0, rd_val} + {1'b0, rs_val};
  assign sub_full = {1'b0, rd_val} - {1'b0, rs_val};

`ifdef CORE_MUL_EN
  logic [2*DATA_W-1:0] mul_full;
  assign mul_full = rd_val * rs_val;
`endif

  always_comb begin
    alu_res = rd_val;
    alu_c   = znc_reg[0];
    reg_wr  = 1'b0;
    flag_wr = 1'b0;
    case (op)
      OP_LDI: begin alu_res = imm_data; reg_wr = 1'b1; end
      OP_MOV: begin alu_res = rs_val;   reg_wr = 1'b1; end
      OP_ADD: begin {alu_c, alu_res} = add_full; reg_wr = 1'b1; flag_wr = 1'b1; end
      OP_SUB: begin {alu_c, alu_res} = sub_full; reg_wr = 1'b1; flag_wr = 1'b1; end
      OP_AND: begin alu_res = rd_val & rs_val; alu_c = 1'b0; reg_wr = 1'b1; flag_wr = 1'b1; end
      OP_OR:  begin alu_res = rd_val | rs_val; alu_c = 1'b0; reg_wr = 1'b1; flag_wr = 1'b1; end
      OP_XOR: begin alu_res = rd_val ^ rs_val; alu_c = 1'b0; reg_wr = 1'b1; flag_wr = 1'b1; end
      OP_SHL: begin
        alu_res = {rd_val[DATA_W-2:0], 1'b0};
        alu_c   = rd_val[DATA_W-1];
        reg_wr  = 1'b1;
        flag_wr = 1'b1;
      end
      OP_SHR: begin
        alu_res = {1'b0, rd_val[DATA_W-1:1]};
        alu_c   = rd_val[0];
        reg_wr  = 1'b1;
        flag_wr = 1'b1;
      end
`ifdef CORE_MUL_EN
      OP_MUL: begin
        alu_res = mul_full[DATA_W-1:0];
        alu_c   = |mul_full[2*DATA_W-1:DATA_W];
        reg_wr  = 1'b1;
        flag_wr = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign br_take = ((op == OP_BRZ) && znc_reg[2]) ||
                   ((op == OP_BRC) && znc_reg[0]) ||
                   (op == OP_JMP);

  for (genvar gi = 0; gi < 4; gi++) begin : g_rf_we
    assign rf_we[gi] = (state_reg == EXEC) && reg_wr && (rd == 2'(gi));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= FETCH;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH: if (imem_valid) state_next = EXEC;
      EXEC: begin
        if (op == OP_OUT)      state_next = OUTW;
        else if (op == OP_HLT) state_next = HALT;
        else                   state_next = FETCH;
      end
      OUTW:  if (out_ready) state_next = FETCH;
      HALT:  state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  // Outputs; fetch request is masked by reset itself so it drops immediately.
  always_comb begin
    imem_req  = (state_reg == FETCH) && !rst;
    out_valid = (state_reg == OUTW);
    halted    = (state_reg == HALT);
  end

  assign imem_addr = pc_reg;
  assign pc        = pc_reg;
  assign znc       = znc_reg;
  assign out_data  = out_data_reg;

  // pc already points past the branch when EXEC runs, so offsets are relative to it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg       <= '0;
      ir_reg       <= '0;
      znc_reg      <= 3'b000;
      out_data_reg <= '0;
    end else begin
      if ((state_reg == FETCH) && imem_valid) begin
        ir_reg <= imem_data;
        pc_reg <= pc_reg + 1'b1;
      end
      if (state_reg == EXEC) begin
        if (br_take) pc_reg <= pc_reg + imm_pc;
        if (flag_wr) znc_reg <= {(alu_res == '0), alu_res[DATA_W-1], alu_c};
        if (op == OP_OUT) out_data_reg <= rd_val;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs_reg[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (rf_we[i]) regs_reg[i] <= alu_res;
    end
  end

endmodule
